// File: rtl/csr_reg_pkg.sv
// csr_reg_pkg: CSR addresses, widths and decode helpers shared by csr_reg and clint
package csr_reg_pkg;
  localparam int CSR_W_DEF  = 32;
  localparam int ADDR_W_DEF = 32;
  localparam int CSR_AW     = 12;
  localparam int HALF_W     = 32;
  localparam int CNT_W      = 2 * HALF_W;
  localparam int MSTATUS_MIE = 3;
  localparam logic WE_ON  = 1'b1;
  localparam logic WE_OFF = 1'b0;
  localparam logic [CSR_AW-1:0] CSR_MSTATUS  = 12'h300;
  localparam logic [CSR_AW-1:0] CSR_MIE      = 12'h304;
  localparam logic [CSR_AW-1:0] CSR_MTVEC    = 12'h305;
  localparam logic [CSR_AW-1:0] CSR_MSCRATCH = 12'h340;
  localparam logic [CSR_AW-1:0] CSR_MEPC     = 12'h341;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE   = 12'h342;
  localparam logic [CSR_AW-1:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [CSR_AW-1:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [CSR_AW-1:0] CSR_CYCLE    = 12'hC00;
  localparam logic [CSR_AW-1:0] CSR_CYCLEH   = 12'hC80;
  typedef enum logic [3:0] {
    SEL_NONE, SEL_MSTATUS, SEL_MIE, SEL_MTVEC, SEL_MSCRATCH, SEL_MEPC,
    SEL_MCAUSE, SEL_MCYCLE, SEL_MCYCLEH, SEL_CYCLE, SEL_CYCLEH
  } csr_sel_e;
  function automatic csr_sel_e csr_decode(input logic [CSR_AW-1:0] a);
    case (a)
      CSR_MSTATUS:  return SEL_MSTATUS;
      CSR_MIE:      return SEL_MIE;
      CSR_MTVEC:    return SEL_MTVEC;
      CSR_MSCRATCH: return SEL_MSCRATCH;
      CSR_MEPC:     return SEL_MEPC;
      CSR_MCAUSE:   return SEL_MCAUSE;
      CSR_MCYCLE:   return SEL_MCYCLE;
      CSR_MCYCLEH:  return SEL_MCYCLEH;
      CSR_CYCLE:    return SEL_CYCLE;
      CSR_CYCLEH:   return SEL_CYCLEH;
      default:      return SEL_NONE;
    endcase
  endfunction
  function automatic logic csr_writable(input csr_sel_e s);
    return !(s inside {SEL_NONE, SEL_CYCLE, SEL_CYCLEH});
  endfunction
  function automatic logic csr_aligned(input csr_sel_e s);
    return s inside {SEL_MTVEC, SEL_MEPC};
  endfunction
endpackage

// File: rtl/csr_reg_cycle_cnt.sv
// csr_cycle_cnt: free-running 64-bit cycle counter with per-half load
module csr_cycle_cnt
  import csr_reg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_lo_i,
  input  logic              load_hi_i,
  input  logic [HALF_W-1:0] wdata_i,
  output logic [CNT_W-1:0]  cnt_o
);
  logic [CNT_W-1:0] cnt_d, cnt_q;
  // a half load freezes the other half: no increment and no carry that cycle
  always_comb begin
    cnt_d = load_lo_i ? {cnt_q[CNT_W-1:HALF_W], wdata_i} :
            load_hi_i ? {wdata_i, cnt_q[HALF_W-1:0]} :
                        cnt_q + CNT_W'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  assign cnt_o = cnt_q;
endmodule

// File: rtl/csr_reg.sv
// csr_reg: machine-mode CSR file with execute and trap-controller write ports
module csr_reg
  import csr_reg_pkg::*;
#(
  parameter int CSR_W  = CSR_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_we_i,
  input  logic [ADDR_W-1:0] ex_waddr_i,
  input  logic [CSR_W-1:0]  ex_wdata_i,
  input  logic [ADDR_W-1:0] id_raddr_i,
  output logic [CSR_W-1:0]  id_rdata_o,
  input  logic              clint_we_i,
  input  logic [ADDR_W-1:0] clint_waddr_i,
  input  logic [CSR_W-1:0]  clint_wdata_i,
  output logic [CSR_W-1:0]  clint_mtvec_o,
  output logic [CSR_W-1:0]  clint_mepc_o,
  output logic [CSR_W-1:0]  clint_mstatus_o,
  output logic              global_int_en_o
);
  logic                 we;
  logic [ADDR_W-1:0]    waddr;
  logic [CSR_W-1:0]     wdata, wdata_m, rdata;
  csr_sel_e             wsel, rsel;
  logic [CNT_W-1:0]     cnt;
  logic [CSR_W-1:0]     mstatus_d, mie_d, mtvec_d, mscratch_d, mepc_d, mcause_d;
  logic [CSR_W-1:0]     mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic                 unused_addr;
  // trap-controller port wins outright; a colliding ex write is dropped
  assign we      = !rst && (clint_we_i || ex_we_i);
  assign waddr   = clint_we_i ? clint_waddr_i : ex_waddr_i;
  assign wdata   = clint_we_i ? clint_wdata_i : ex_wdata_i;
  assign wsel    = csr_decode(waddr[CSR_AW-1:0]);
  assign rsel    = csr_decode(id_raddr_i[CSR_AW-1:0]);
  assign wdata_m = csr_aligned(wsel) ? {wdata[CSR_W-1:2], 2'b00} : wdata;
  assign unused_addr = ^{ex_waddr_i, clint_waddr_i, id_raddr_i};
  always_comb begin
    mstatus_d  = (we && wsel == SEL_MSTATUS)  ? wdata_m : mstatus_q;
    mie_d      = (we && wsel == SEL_MIE)      ? wdata_m : mie_q;
    mtvec_d    = (we && wsel == SEL_MTVEC)    ? wdata_m : mtvec_q;
    mscratch_d = (we && wsel == SEL_MSCRATCH) ? wdata_m : mscratch_q;
    mepc_d     = (we && wsel == SEL_MEPC)     ? wdata_m : mepc_q;
    mcause_d   = (we && wsel == SEL_MCAUSE)   ? wdata_m : mcause_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_q  <= '0;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end
  csr_cycle_cnt u_cnt (
    .clk       (clk),
    .rst       (rst),
    .load_lo_i (we && wsel == SEL_MCYCLE),
    .load_hi_i (we && wsel == SEL_MCYCLEH),
    .wdata_i   (wdata_m[HALF_W-1:0]),
    .cnt_o     (cnt)
  );
  always_comb begin
    rdata = '0;
    case (rsel)
      SEL_MSTATUS:           rdata = mstatus_q;
      SEL_MIE:               rdata = mie_q;
      SEL_MTVEC:             rdata = mtvec_q;
      SEL_MSCRATCH:          rdata = mscratch_q;
      SEL_MEPC:              rdata = mepc_q;
      SEL_MCAUSE:            rdata = mcause_q;
      SEL_MCYCLE, SEL_CYCLE:   rdata = CSR_W'(cnt[HALF_W-1:0]);
      SEL_MCYCLEH, SEL_CYCLEH: rdata = CSR_W'(cnt[CNT_W-1:HALF_W]);
      default:               rdata = '0;
    endcase
    id_rdata_o = (we && csr_writable(wsel) && waddr[CSR_AW-1:0] == id_raddr_i[CSR_AW-1:0])
                 ? wdata_m : rdata;
  end
  assign clint_mtvec_o   = mtvec_q;
  assign clint_mepc_o    = mepc_q;
  assign clint_mstatus_o = mstatus_q;
  assign global_int_en_o = mstatus_q[MSTATUS_MIE];
endmodule

// File: tb/tb_csr_reg.sv
// tb_csr_reg: directed plus randomized checks of csr_reg against an address-map model
module tb_csr_reg;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_we_i = 1'b0, clint_we_i = 1'b0;
  logic [31:0] ex_waddr_i = '0, ex_wdata_i = '0, id_raddr_i = '0;
  logic [31:0] clint_waddr_i = '0, clint_wdata_i = '0;
  logic [31:0] id_rdata_o, clint_mtvec_o, clint_mepc_o, clint_mstatus_o;
  logic        global_int_en_o;
  int n_cmp = 0, n_err = 0;
  logic [31:0] m [int];
  logic [63:0] cnt;
  int pool [12] = '{'h300, 'h304, 'h305, 'h340, 'h341, 'h342, 'hB00, 'hB80, 'hC00, 'hC80, 'h123, 'h7FF};

  csr_reg dut (
    .clk(clk), .rst(rst),
    .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
    .id_raddr_i(id_raddr_i), .id_rdata_o(id_rdata_o),
    .clint_we_i(clint_we_i), .clint_waddr_i(clint_waddr_i), .clint_wdata_i(clint_wdata_i),
    .clint_mtvec_o(clint_mtvec_o), .clint_mepc_o(clint_mepc_o),
    .clint_mstatus_o(clint_mstatus_o), .global_int_en_o(global_int_en_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    foreach (pool[i]) if (i < 6) m[pool[i]] = 32'h0;
    cnt = 64'h0;
  endfunction

  function automatic logic [31:0] mread(input int a);
    if (a == 'hB00 || a == 'hC00) return cnt[31:0];
    if (a == 'hB80 || a == 'hC80) return cnt[63:32];
    return m.exists(a) ? m[a] : 32'h0;
  endfunction

  function automatic bit writable(input int a);
    return m.exists(a) || a == 'hB00 || a == 'hB80;
  endfunction

  function automatic logic [31:0] masked(input int a, input logic [31:0] d);
    return (a == 'h305 || a == 'h341) ? (d & 32'hFFFF_FFFC) : d;
  endfunction

  function automatic void winner(output bit v, output int a, output logic [31:0] d);
    v = !rst && (clint_we_i || ex_we_i);
    a = int'(clint_we_i ? clint_waddr_i % 4096 : ex_waddr_i % 4096);
    d = clint_we_i ? clint_wdata_i : ex_wdata_i;
  endfunction

  function automatic logic [31:0] model_rd();
    bit v; int a; logic [31:0] d;
    int ra = int'(id_raddr_i % 4096);
    winner(v, a, d);
    return (v && a == ra && writable(a)) ? masked(a, d) : mread(ra);
  endfunction

  function automatic void model_update();
    bit v; int a; logic [31:0] d; logic [63:0] nc;
    if (rst) begin
      model_reset();
      return;
    end
    winner(v, a, d);
    nc = cnt + 64'd1;
    if (v && a == 'hB00) nc = {cnt[63:32], d};
    else if (v && a == 'hB80) nc = {d, cnt[31:0]};
    else if (v && m.exists(a)) m[a] = masked(a, d);
    cnt = nc;
  endfunction

  task automatic drive(input logic ew, input logic [31:0] ea, input logic [31:0] ed,
                       input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic [31:0] ra);
    ex_we_i = ew; ex_waddr_i = ea; ex_wdata_i = ed;
    clint_we_i = cw; clint_waddr_i = ca; clint_wdata_i = cd;
    id_raddr_i = ra;
  endtask

  task automatic step();
    #1;
    check("id_rdata", id_rdata_o, model_rd());
    check("mtvec", clint_mtvec_o, mread('h305));
    check("mepc", clint_mepc_o, mread('h341));
    check("mstatus", clint_mstatus_o, mread('h300));
    check("gie", 32'(global_int_en_o), (mread('h300) >> 3) & 32'h1);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] r;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 32'hC00);
    #1;
    check("rst_cycle", id_rdata_o, 32'h0);
    check("rst_mtvec", clint_mtvec_o, 32'h0);
    check("rst_mepc", clint_mepc_o, 32'h0);
    check("rst_mstatus", clint_mstatus_o, 32'h0);
    check("rst_gie", 32'(global_int_en_o), 32'h0);
    repeat (10) step();
    #1 check("cycle10", id_rdata_o, 32'd10);
    // mtvec low bits are forced to zero, visible through forwarding too
    drive(1, 32'h0000_0305, 32'h8000_0103, 0, 0, 0, 32'hABC0_0305);
    #1 check("mtvec_fwd", id_rdata_o, 32'h8000_0100);
    step();
    drive(0, 0, 0, 0, 0, 0, 32'h305);
    #1 check("mtvec_out", clint_mtvec_o, 32'h8000_0100);
    drive(1, 32'h340, 32'h55, 1, 32'h341, 32'h40, 32'h340);
    step();
    drive(0, 0, 0, 0, 0, 0, 32'h340);
    #1;
    check("mscratch_drop", id_rdata_o, 32'h0);
    check("mepc_clint", clint_mepc_o, 32'h40);
    drive(1, 32'h300, 32'h8, 0, 0, 0, 32'h300);
    #1 check("gie_same", 32'(global_int_en_o), 32'h0);
    step();
    drive(0, 0, 0, 1, 32'h300, 32'h0, 32'h300);
    #1 check("gie_next", 32'(global_int_en_o), 32'h1);
    step();
    drive(0, 0, 0, 0, 0, 0, 32'h300);
    #1 check("gie_clear", 32'(global_int_en_o), 32'h0);
    drive(1, 32'hB00, 32'hFFFF_FFFF, 0, 0, 0, 32'hC00);
    step();
    drive(1, 32'hB80, 32'hFFFF_FFFF, 0, 0, 0, 32'hC80);
    step();
    drive(0, 0, 0, 0, 0, 0, 32'hC80);
    #1 check("cnt_max_hi", id_rdata_o, 32'hFFFF_FFFF);
    step();
    #1 check("wrap_hi", id_rdata_o, 32'h0);
    drive(1, 32'hC00, 32'h1234, 0, 0, 0, 32'hC00);
    #1 check("wrap_lo", id_rdata_o, 32'h0);
    step();
    drive(0, 0, 0, 0, 0, 0, 32'hC00);
    #1 check("ro_ignored", id_rdata_o, 32'h1);
    drive(1, 32'h340, 32'h77, 0, 0, 0, 32'h340);
    step();
    drive(1, 32'h340, 32'hAA, 0, 0, 0, 32'h340);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 32'hC00);
    #1 check("rst_cnt", id_rdata_o, 32'h0);
    id_raddr_i = 32'h340;
    #1 check("rst_mscratch", id_rdata_o, 32'h0);
    check("rst_gie2", 32'(global_int_en_o), 32'h0);
    for (int i = 0; i < 1500; i++) begin
      r = $urandom;
      ex_we_i = 1'($urandom_range(0, 1));
      ex_waddr_i = ($urandom_range(0, 7) == 0) ? $urandom : {r[31:12], 12'(pool[$urandom_range(0, 11)])};
      ex_wdata_i = $urandom;
      r = $urandom;
      clint_we_i = ($urandom_range(0, 3) == 0);
      clint_waddr_i = {r[31:12], 12'(pool[$urandom_range(0, 11)])};
      clint_wdata_i = $urandom;
      r = $urandom;
      id_raddr_i = ($urandom_range(0, 1) == 0) ? ex_waddr_i : {r[31:12], 12'(pool[$urandom_range(0, 11)])};
      rst = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/csr_reg.md
CSR_REG -- requirements
Module: csr_reg

Interface
REQ-001 SHALL have reset rst, synchronous, active-high.
REQ-002 SHALL use parameter CSR_W, default 32, CSR data width.
REQ-003 SHALL use parameter ADDR_W, default 32, CSR address width; only bits [11:0] decoded, upper bits SHALL be ignored.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 ex_we_i  in  1  write enable from execute stage (CSR instructions).
REQ-007 ex_waddr_i  in  ADDR_W  execute-stage write address.
REQ-008 ex_wdata_i  in  CSR_W  execute-stage write data.
REQ-009 id_raddr_i  in  ADDR_W  decode-stage read address.
REQ-010 id_rdata_o  out  CSR_W  decode-stage read data, combinational.
REQ-011 clint_we_i / clint_waddr_i / clint_wdata_i  in  1/ADDR_W/CSR_W  trap-controller write port.
REQ-012 clint_mtvec_o, clint_mepc_o, clint_mstatus_o  out  CSR_W  registered values to trap controller.
REQ-013 global_int_en_o  out  1  equals registered mstatus[3] (MIE).

Function
REQ-014 SHALL implement mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00, mcycleh 0xB80 (read/write), cycle 0xC00, cycleh 0xC80 (read-only aliases).
REQ-015 Writes SHALL take effect at the rising edge; direct outputs reflect new value the following cycle.
REQ-016 Same-cycle writes from both ports SHALL resolve with clint port priority; colliding ex write is discarded regardless of address.
REQ-017 mtvec[1:0] and mepc[1:0] SHALL always read 0 (writes to those bits ignored).
REQ-018 Writes to unmapped addresses or read-only aliases SHALL be ignored; reads of unmapped addresses SHALL return 0.
REQ-019 64-bit cycle counter SHALL increment by 1 every cycle out of reset, wrapping 0xFFFF_FFFF_FFFF_FFFF -> 0.
REQ-020 A write to mcycle/mcycleh SHALL load that half with wdata and hold the other half that cycle (no increment, no carry).
REQ-021 id_rdata_o SHALL forward: if the winning write (per REQ-016) targets id_raddr_i in the same cycle and the address is writable, return the post-mask write data; else return the stored value.
REQ-022 Reading cycle/mcycle SHALL return the counter low half; cycleh/mcycleh the high half; no forwarding for counter increment.
REQ-023 global_int_en_o SHALL not be forwarded; it changes one cycle after an mstatus write.

Reset
REQ-024 On rst all CSRs including counter SHALL clear to 0; all outputs therefore 0 the cycle after rst is sampled.
REQ-025 Writes presented while rst is high SHALL be ignored; rst mid-count SHALL zero the counter immediately.

Structure
REQ-026 CSR addresses (CSR_MSTATUS etc.), bus widths and enable constants SHALL reside in the shared defines package used by clint.
REQ-027 The 64-bit counter SHALL be a sub-module csr_cycle_cnt (load-low, load-high, increment).
REQ-028 Remaining logic SHALL be a single register block with one address decoder shared by both write ports.

Verification
REQ-029 Reset then 10 idle cycles -> read 0xC00 returns 10 (±0 with defined sampling), all direct outputs 0.
REQ-030 ex write 0x305 = 0x8000_0103 -> next cycle clint_mtvec_o = 0x8000_0100; same-cycle id read of 0x305 returns 0x8000_0100.
REQ-031 Same cycle clint write 0x341 = 0x40 and ex write 0x340 = 0x55 -> mepc = 0x40, mscratch unchanged 0.
REQ-032 ex write 0x300 = 0x8 -> global_int_en_o 0 that cycle, 1 next cycle; clint write 0x300 = 0x0 -> 0 next cycle.
REQ-033 Write mcycle = 0xFFFF_FFFF, mcycleh = 0xFFFF_FFFF on consecutive cycles -> counter wraps to 0 and resumes counting; write to 0xC00 ignored.
REQ-034 Assert rst mid-count with pending ex write -> counter and all CSRs read 0 after release; write not applied.
